// File: rtl/regfile_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wr_arbiter
// Description : Two-requester register-file write arbiter (round-robin on
//               contention) with a sequenced clear of registers 1..DEPTH-1.
//               Drives a single registered write port into the register file.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wr_arbiter #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int REG_WIDTH      = 32,
    parameter int REGFILE_DEPTH  = 32
) (
    input  logic                      clk,
    input  logic                      rstn,
    // requester A: execute writeback
    input  logic                      a_valid,
    output logic                      a_ready,
    input  logic [REG_ADDR_WIDTH-1:0] a_addr,
    input  logic [REG_WIDTH-1:0]      a_data,
    // requester B: load writeback
    input  logic                      b_valid,
    output logic                      b_ready,
    input  logic [REG_ADDR_WIDTH-1:0] b_addr,
    input  logic [REG_WIDTH-1:0]      b_data,
    // clear control
    input  logic                      clr_req,
    output logic                      clr_busy,
    output logic                      clr_done,
    // registered register-file write port
    output logic                      wr_en,
    output logic [REG_ADDR_WIDTH-1:0] wr_addr,
    output logic [REG_WIDTH-1:0]      wr_data
);

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        CLEAR = 1'b1
    } state_t;

    // last_grant encoding: 0 = A, 1 = B
    localparam logic                      c_GRANT_A  = 1'b0;
    localparam logic                      c_GRANT_B  = 1'b1;
    localparam logic [REG_ADDR_WIDTH-1:0] c_CNT_LAST = REG_ADDR_WIDTH'(REGFILE_DEPTH - 1);
    localparam logic [REG_ADDR_WIDTH-1:0] c_CNT_INIT = REG_ADDR_WIDTH'(1);

    state_t                    state_q;
    logic [REG_ADDR_WIDTH-1:0] cnt_q;
    logic                      last_grant_q;
    logic                      wr_en_q;
    logic [REG_ADDR_WIDTH-1:0] wr_addr_q;
    logic [REG_WIDTH-1:0]      wr_data_q;
    logic                      clr_done_q;

    logic                      w_accept_ok;
    logic                      w_a_hs;
    logic                      w_b_hs;

    // Ready generation: requests are accepted only in RUN with no pending
    // clear and outside reset; contention goes to the requester not granted
    // last time. Readies depend only on valids, never on each other.
    always_comb begin
        w_accept_ok = rstn && (state_q == RUN) && !clr_req;
        a_ready     = w_accept_ok && a_valid && (!b_valid || (last_grant_q == c_GRANT_B));
        b_ready     = w_accept_ok && b_valid && (!a_valid || (last_grant_q == c_GRANT_A));
        w_a_hs      = a_valid && a_ready;
        w_b_hs      = b_valid && b_ready;
    end

    // Arbiter / clear sequencer FSM with registered write port and done pulse.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= RUN;
            cnt_q        <= c_CNT_INIT;
            last_grant_q <= c_GRANT_B;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            clr_done_q   <= 1'b0;
        end else begin
            clr_done_q <= 1'b0;
            case (state_q)
                RUN: begin
                    wr_en_q <= 1'b0;
                    if (clr_req) begin
                        state_q <= CLEAR;
                        cnt_q   <= c_CNT_INIT;
                    end else if (w_a_hs) begin
                        last_grant_q <= c_GRANT_A;
                        // writes to x0 are accepted but discarded
                        if (a_addr != '0) begin
                            wr_en_q   <= 1'b1;
                            wr_addr_q <= a_addr;
                            wr_data_q <= a_data;
                        end
                    end else if (w_b_hs) begin
                        last_grant_q <= c_GRANT_B;
                        if (b_addr != '0) begin
                            wr_en_q   <= 1'b1;
                            wr_addr_q <= b_addr;
                            wr_data_q <= b_data;
                        end
                    end
                end
                CLEAR: begin
                    wr_en_q   <= 1'b1;
                    wr_addr_q <= cnt_q;
                    wr_data_q <= '0;
                    if (cnt_q == c_CNT_LAST) begin
                        // counter re-armed to 1 so it never holds address 0
                        state_q    <= RUN;
                        cnt_q      <= c_CNT_INIT;
                        clr_done_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= RUN;
                    wr_en_q <= 1'b0;
                end
            endcase
        end
    end

    assign clr_busy = (state_q == CLEAR);
    assign clr_done = clr_done_q;
    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_wr_arbiter
// Description : Directed self-checking bench for regfile_wr_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wr_arbiter;

    localparam int c_AW    = 5;
    localparam int c_DW    = 32;
    localparam int c_DEPTH = 32;

    logic            clk;
    logic            rstn;
    logic            a_valid, a_ready, b_valid, b_ready;
    logic [c_AW-1:0] a_addr, b_addr, wr_addr;
    logic [c_DW-1:0] a_data, b_data, wr_data;
    logic            clr_req, clr_busy, clr_done, wr_en;

    int checks   = 0;
    int failures = 0;

    regfile_wr_arbiter #(
        .REG_ADDR_WIDTH (c_AW),
        .REG_WIDTH      (c_DW),
        .REGFILE_DEPTH  (c_DEPTH)
    ) u_dut (
        .clk      (clk),
        .rstn     (rstn),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .a_addr   (a_addr),
        .a_data   (a_data),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .b_addr   (b_addr),
        .b_data   (b_data),
        .clr_req  (clr_req),
        .clr_busy (clr_busy),
        .clr_done (clr_done),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        bit found;
        rstn = 1'b0; clr_req = 1'b0;
        a_valid = 1'b1; a_addr = 5'd9; a_data = 32'h55;
        b_valid = 1'b1; b_addr = 5'd8; b_data = 32'h66;

        // ---------------- reset state ----------------
        #12;
        chk("rst_wr_en",    32'(wr_en),    32'd0);
        chk("rst_wr_addr",  32'(wr_addr),  32'd0);
        chk("rst_wr_data",  wr_data,       32'd0);
        chk("rst_clr_busy", 32'(clr_busy), 32'd0);
        chk("rst_clr_done", 32'(clr_done), 32'd0);
        chk("rst_a_ready",  32'(a_ready),  32'd0);
        chk("rst_b_ready",  32'(b_ready),  32'd0);

        // ---------------- alternating grants after reset ----------------
        @(negedge clk);
        rstn = 1'b1;
        a_addr = 5'd1; a_data = 32'h1111;
        b_addr = 5'd2; b_data = 32'h2222;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rr_a_ready", 32'(a_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("rr_b_ready", 32'(b_ready), (i % 2 == 0) ? 32'd0 : 32'd1);
            @(posedge clk); #1;
            chk("rr_wr_en",   32'(wr_en),   32'd1);
            chk("rr_wr_addr", 32'(wr_addr), (i % 2 == 0) ? 32'd1 : 32'd2);
            chk("rr_wr_data", wr_data,      (i % 2 == 0) ? 32'h1111 : 32'h2222);
            @(negedge clk);
        end

        // ---------------- A only ----------------
        b_valid = 1'b0;
        a_addr = 5'd5; a_data = 32'hDEADBEEF;
        #1;
        chk("aonly_a_ready", 32'(a_ready), 32'd1);
        chk("aonly_b_ready", 32'(b_ready), 32'd0);
        @(posedge clk); #1;
        chk("aonly_wr_en",   32'(wr_en),   32'd1);
        chk("aonly_wr_addr", 32'(wr_addr), 32'd5);
        chk("aonly_wr_data", wr_data,      32'hDEADBEEF);

        // ---------------- A write to x0 ----------------
        @(negedge clk);
        a_addr = 5'd0; a_data = 32'h1234;
        #1;
        chk("x0_a_ready", 32'(a_ready), 32'd1);
        @(posedge clk); #1;
        chk("x0_wr_en",   32'(wr_en),   32'd0);
        chk("x0_wr_addr", 32'(wr_addr), 32'd5);
        chk("x0_wr_data", wr_data,      32'hDEADBEEF);

        // ---------------- B only ----------------
        @(negedge clk);
        a_valid = 1'b0;
        b_valid = 1'b1; b_addr = 5'd7; b_data = 32'hCAFE;
        #1;
        chk("bonly_a_ready", 32'(a_ready), 32'd0);
        chk("bonly_b_ready", 32'(b_ready), 32'd1);
        @(posedge clk); #1;
        chk("bonly_wr_en",   32'(wr_en),   32'd1);
        chk("bonly_wr_addr", 32'(wr_addr), 32'd7);
        chk("bonly_wr_data", wr_data,      32'hCAFE);

        // ---------------- idle ----------------
        @(negedge clk);
        b_valid = 1'b0;
        @(posedge clk); #1;
        chk("idle_wr_en", 32'(wr_en), 32'd0);

        // ---------------- clear wins over simultaneous requests ----------------
        @(negedge clk);
        clr_req = 1'b1;
        a_valid = 1'b1; a_addr = 5'd3; a_data = 32'h3333;
        b_valid = 1'b1; b_addr = 5'd4; b_data = 32'h4444;
        #1;
        chk("clr_a_ready", 32'(a_ready), 32'd0);
        chk("clr_b_ready", 32'(b_ready), 32'd0);
        @(posedge clk); #1;
        chk("clr_busy_start", 32'(clr_busy), 32'd1);
        chk("clr_wr_en_start", 32'(wr_en),   32'd0);
        chk("clr_a_ready_busy", 32'(a_ready), 32'd0);
        for (int k = 1; k <= 31; k++) begin
            @(posedge clk); #1;
            chk("clr_wr_en",   32'(wr_en),    32'd1);
            chk("clr_wr_addr", 32'(wr_addr),  32'(k));
            chk("clr_wr_data", wr_data,       32'd0);
            chk("clr_done",    32'(clr_done), (k == 31) ? 32'd1 : 32'd0);
            chk("clr_busy",    32'(clr_busy), (k == 31) ? 32'd0 : 32'd1);
            // last completed handshake was B, so A wins once RUN resumes
            chk("clr_a_ready_seq", 32'(a_ready), (k == 31) ? 32'd1 : 32'd0);
            chk("clr_b_ready_seq", 32'(b_ready), 32'd0);
            if (k == 1) begin
                // clr_req held into CLEAR must not restart the sequence
                @(negedge clk);
                clr_req = 1'b0;
            end
        end
        @(posedge clk); #1;
        chk("post_clr_done", 32'(clr_done), 32'd0);
        chk("post_clr_wr_en", 32'(wr_en),   32'd1);
        chk("post_clr_addr", 32'(wr_addr),  32'd3);
        chk("post_clr_data", wr_data,       32'h3333);
        chk("post_clr_b_ready", 32'(b_ready), 32'd1);
        @(negedge clk);
        a_valid = 1'b0; b_valid = 1'b0;

        // ---------------- reset mid-clear ----------------
        clr_req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clr_req = 1'b0;
        found = 1'b0;
        for (int n = 0; n < 40 && !found; n++) begin
            @(posedge clk); #1;
            if (wr_en && wr_addr == 5'd10) found = 1'b1;
        end
        chk("abort_reached_addr10", 32'(found), 32'd1);
        rstn = 1'b0;
        #1;
        chk("abort_wr_en",    32'(wr_en),    32'd0);
        chk("abort_clr_busy", 32'(clr_busy), 32'd0);
        chk("abort_wr_addr",  32'(wr_addr),  32'd0);
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        for (int n = 0; n < 5; n++) begin
            @(posedge clk); #1;
            chk("abort_no_resume_en",   32'(wr_en),    32'd0);
            chk("abort_no_resume_busy", 32'(clr_busy), 32'd0);
        end
        @(negedge clk);
        a_valid = 1'b1; a_addr = 5'd12; a_data = 32'hA5A5;
        b_valid = 1'b1; b_addr = 5'd13; b_data = 32'h5A5A;
        #1;
        chk("resume_a_ready", 32'(a_ready), 32'd1);
        chk("resume_b_ready", 32'(b_ready), 32'd0);
        @(posedge clk); #1;
        chk("resume_wr_en",   32'(wr_en),   32'd1);
        chk("resume_wr_addr", 32'(wr_addr), 32'd12);
        chk("resume_wr_data", wr_data,      32'hA5A5);
        @(negedge clk);
        a_valid = 1'b0;
        #1;
        chk("resume_b_only_ready", 32'(b_ready), 32'd1);
        @(posedge clk); #1;
        chk("resume_b_wr_addr", 32'(wr_addr), 32'd13);
        @(negedge clk);
        b_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
